// File: rtl/sipo_capture_ctrl.sv
// Serial-to-parallel capture stage: assembles WIDTH enable-qualified bits into a
// registered word with a one-cycle QV strobe. Define SIPO_CAPTURE_PARITY_EN for a trailing parity bit.
module sipo_capture_ctrl #(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int ODD_PARITY = 0
) (
    input  logic             C,
    input  logic             R,
    input  logic             D,
    input  logic             E,
    input  logic             CLR,
    output logic [WIDTH-1:0] Q,
    output logic             QV,
    output logic             BUSY,
    output logic             PERR
);

    localparam int              CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic            PAR_SENSE = (ODD_PARITY != 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PAR   = 2'd2;

    logic [WIDTH-1:0] sreg_reg  = '0;
    logic [WIDTH-1:0] sreg_next;
    logic [CNT_W-1:0] cnt_reg   = '0;
    logic [CNT_W-1:0] cnt_next;
    logic [1:0]       state_reg = ST_IDLE;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] q_reg     = '0;
    logic [WIDTH-1:0] q_next;
    logic             qv_reg    = 1'b0;
    logic             qv_next;
    logic [WIDTH-1:0] shift_word;

    // Word as it will look once the current D has been shifted in.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign shift_word = {sreg_reg[WIDTH-2:0], D};
        end else begin : g_lsb_first
            assign shift_word = {D, sreg_reg[WIDTH-1:1]};
        end
    endgenerate

`ifdef SIPO_CAPTURE_PARITY_EN
    logic perr_reg = 1'b0;
    logic perr_next;
    logic parity_bad;

    assign parity_bad = ^{sreg_reg, D, PAR_SENSE};
`endif

    always_comb begin
        sreg_next  = sreg_reg;
        cnt_next   = cnt_reg;
        state_next = state_reg;
        q_next     = q_reg;
        qv_next    = 1'b0;
`ifdef SIPO_CAPTURE_PARITY_EN
        perr_next  = 1'b0;
`endif
        if (CLR) begin
            // Abort drops the partial word and any pending parity bit; Q keeps the last word.
            sreg_next  = '0;
            cnt_next   = '0;
            state_next = ST_IDLE;
        end else if (E) begin
            case (state_reg)
`ifdef SIPO_CAPTURE_PARITY_EN
                ST_PAR: begin
                    q_next     = sreg_reg;
                    qv_next    = 1'b1;
                    perr_next  = parity_bad;
                    sreg_next  = '0;
                    state_next = ST_IDLE;
                end
`endif
                default: begin
                    sreg_next = shift_word;
                    if (cnt_reg == LAST_CNT) begin
                        cnt_next = '0;
`ifdef SIPO_CAPTURE_PARITY_EN
                        state_next = ST_PAR;
`else
                        q_next     = shift_word;
                        qv_next    = 1'b1;
                        state_next = ST_IDLE;
`endif
                    end else begin
                        cnt_next   = cnt_reg + 1'b1;
                        state_next = ST_SHIFT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge C) begin
        if (!R) begin
            sreg_reg  <= '0;
            cnt_reg   <= '0;
            state_reg <= ST_IDLE;
            q_reg     <= '0;
            qv_reg    <= 1'b0;
        end else begin
            sreg_reg  <= sreg_next;
            cnt_reg   <= cnt_next;
            state_reg <= state_next;
            q_reg     <= q_next;
            qv_reg    <= qv_next;
        end
    end

`ifdef SIPO_CAPTURE_PARITY_EN
    always_ff @(posedge C) begin
        if (!R) begin
            perr_reg <= 1'b0;
        end else begin
            perr_reg <= perr_next;
        end
    end

    assign PERR = perr_reg;
`else
    // Parity sense only matters when the parity bit exists.
    assign PERR = PAR_SENSE & 1'b0;
`endif

    assign Q    = q_reg;
    assign QV   = qv_reg;
    assign BUSY = (cnt_reg != '0) || (state_reg == ST_PAR);

endmodule

// File: tb/tb_sipo_capture_ctrl.sv
// Directed bench for sipo_capture_ctrl: one MSB-first and one LSB-first instance
// fed the same serial stream, with hand-computed expected words.
module tb_sipo_capture_ctrl;

`ifdef SIPO_CAPTURE_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       C = 1'b0;
    logic       R = 1'b0;
    logic       D = 1'b0;
    logic       E = 1'b0;
    logic       CLR = 1'b0;
    logic [7:0] q_msb, q_lsb;
    logic       qv_msb, qv_lsb, busy_msb, busy_lsb, perr_msb, perr_lsb;

    int checks   = 0;
    int failures = 0;

    always #5 C = ~C;

    sipo_capture_ctrl #(.WIDTH(8), .MSB_FIRST(1), .ODD_PARITY(0)) u_msb (
        .C(C), .R(R), .D(D), .E(E), .CLR(CLR),
        .Q(q_msb), .QV(qv_msb), .BUSY(busy_msb), .PERR(perr_msb)
    );

    sipo_capture_ctrl #(.WIDTH(8), .MSB_FIRST(0), .ODD_PARITY(0)) u_lsb (
        .C(C), .R(R), .D(D), .E(E), .CLR(CLR),
        .Q(q_lsb), .QV(qv_lsb), .BUSY(busy_lsb), .PERR(perr_lsb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge with the given inputs; outputs are stable 1 time unit later.
    task automatic step(input logic r, input logic e, input logic d, input logic clr);
        @(negedge C);
        R = r; E = e; D = d; CLR = clr;
        @(posedge C);
        #1;
    endtask

    // Feeds word msb-first in time (plus parity bit p when compiled in).
    task automatic send_word(input string name, input logic [7:0] word, input logic p,
                             input logic [7:0] exp_msb, input logic [7:0] exp_lsb,
                             input logic exp_perr);
        int nbits;
        nbits = PAR_EN ? 9 : 8;
        for (int i = 0; i < nbits; i++) begin
            step(1'b1, 1'b1, (i < 8) ? word[7 - i] : p, 1'b0);
            if (i < nbits - 1) begin
                check({name, " mid qv"}, {30'd0, qv_msb, qv_lsb}, 32'd0);
                check({name, " mid busy"}, {30'd0, busy_msb, busy_lsb}, 32'd3);
            end
        end
        check({name, " qv"}, {30'd0, qv_msb, qv_lsb}, 32'd3);
        check({name, " q msb"}, {24'd0, q_msb}, {24'd0, exp_msb});
        check({name, " q lsb"}, {24'd0, q_lsb}, {24'd0, exp_lsb});
        check({name, " perr"}, {30'd0, perr_msb, perr_lsb},
              {30'd0, exp_perr & PAR_EN, exp_perr & PAR_EN});
        check({name, " busy after"}, {30'd0, busy_msb, busy_lsb}, 32'd0);
        $display("word %s: q_msb=0x%02h q_lsb=0x%02h perr=%0b", name, q_msb, q_lsb, perr_msb);
    endtask

    initial begin
        // Reset held with E=1, D=1.
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("reset q", {16'd0, q_msb, q_lsb}, 32'd0);
        check("reset qv", {30'd0, qv_msb, qv_lsb}, 32'd0);
        check("reset busy", {30'd0, busy_msb, busy_lsb}, 32'd0);
        check("reset perr", {30'd0, perr_msb, perr_lsb}, 32'd0);

        // 1,0,1,0,0,1,0,1 is a palindrome: both orders give 0xA5 (even ones, p=0 clean).
        send_word("a5", 8'hA5, 1'b0, 8'hA5, 8'hA5, 1'b0);

        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("idle qv drop", {30'd0, qv_msb, qv_lsb}, 32'd0);
        check("idle q hold", {16'd0, q_msb, q_lsb}, 32'hA5A5);

        // 1,1,0,0,0,0,0,0: MSB-first 0xC0, LSB-first 0x03; two ones, p=1 gives error.
        send_word("c0_03", 8'hC0, 1'b1, 8'hC0, 8'h03, 1'b1);

        // 0x3C with a 3-cycle enable gap after bit 4.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int g = 0; g < 3; g++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            check("gap busy", {30'd0, busy_msb, busy_lsb}, 32'd3);
            check("gap qv", {30'd0, qv_msb, qv_lsb}, 32'd0);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("gap pre-last qv", {30'd0, qv_msb, qv_lsb}, 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        if (PAR_EN) begin
            check("gap par wait qv", {30'd0, qv_msb, qv_lsb}, 32'd0);
            step(1'b1, 1'b1, 1'b0, 1'b0);
        end
        check("gap qv", {30'd0, qv_msb, qv_lsb}, 32'd3);
        check("gap q", {16'd0, q_msb, q_lsb}, 32'h3C3C);
        check("gap perr", {30'd0, perr_msb, perr_lsb}, 32'd0);

        // CLR mid-word with E=1: the bit on the CLR edge is dropped.
        for (int b = 0; b < 5; b++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("clr busy", {30'd0, busy_msb, busy_lsb}, 32'd0);
        check("clr qv", {30'd0, qv_msb, qv_lsb}, 32'd0);
        check("clr q hold", {16'd0, q_msb, q_lsb}, 32'h3C3C);
        send_word("ff", 8'hFF, 1'b0, 8'hFF, 8'hFF, 1'b0);

        // Back-to-back with E held high; counter must restart at the boundary.
        send_word("12", 8'h12, 1'b0, 8'h12, 8'h48, 1'b0);
        send_word("34", 8'h34, 1'b1, 8'h34, 8'h2C, 1'b0);

        // Reset after 3 bits: no strobe, Q cleared, state back to idle.
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("midrst qv", {30'd0, qv_msb, qv_lsb}, 32'd0);
        check("midrst busy", {30'd0, busy_msb, busy_lsb}, 32'd0);
        check("midrst q", {16'd0, q_msb, q_lsb}, 32'd0);
        send_word("81", 8'h81, 1'b0, 8'h81, 8'h81, 1'b0);

        // 0x07 has three ones: parity bit 1 is clean, 0 is an error.
        // LSB-first of bits 0,0,0,0,0,1,1,1 is 0xE0.
        send_word("07p1", 8'h07, 1'b1, 8'h07, 8'hE0, 1'b0);
        send_word("07p0", 8'h07, 1'b0, 8'h07, 8'hE0, 1'b1);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("final perr drop", {30'd0, perr_msb, perr_lsb}, 32'd0);
        check("final qv drop", {30'd0, qv_msb, qv_lsb}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
